// File: rtl/pipe_ex_stage.sv
// Execute stage of a five-stage pipeline: ID/EX register with bubble insertion,
// operand forwarding from MEM/WB, and a 32-bit ALU with zero/overflow flags.
module pipe_ex_stage (
  input  logic        clk,
  input  logic        clr,
  input  logic        IFwip,
  input  logic        IDwreg,
  input  logic        IDm2reg,
  input  logic        IDwmem,
  input  logic [3:0]  IDaluc,
  input  logic [1:0]  IDselectAlua,
  input  logic [1:0]  IDselectAlub,
  input  logic [4:0]  IDwn,
  input  logic [31:0] IDqa,
  input  logic [31:0] IDqb,
  input  logic [31:0] IDsaOrImme,
  input  logic [31:0] MEMalu,
  input  logic [31:0] WBdata,
  output logic        EXwreg,
  output logic        EXm2reg,
  output logic        EXwmem,
  output logic [4:0]  EXwn,
  output logic [31:0] EXalu,
  output logic [31:0] EXqb,
  output logic        EXzero,
  output logic        EXovf
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_NOR  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_LUI  = 4'b1011,
    ALU_PASB = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_REG = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10,
    SEL_IMM = 2'b11
  } opnd_sel_e;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    alu_op_e     aluc;
    opnd_sel_e   sel_a;
    opnd_sel_e   sel_b;
    logic [4:0]  wn;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
  } idex_t;

  idex_t id_d;
  idex_t ex_q;

  assign id_d = '{
    wreg:  IDwreg,
    m2reg: IDm2reg,
    wmem:  IDwmem,
    aluc:  alu_op_e'(IDaluc),
    sel_a: opnd_sel_e'(IDselectAlua),
    sel_b: opnd_sel_e'(IDselectAlub),
    wn:    IDwn,
    qa:    IDqa,
    qb:    IDqb,
    imm:   IDsaOrImme
  };

  // All-zero register is the bubble: no write enables and an ADD of 0+0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values in the same step.
    if (clr || !IFwip) ex_q <= '0;
    else               ex_q <= id_d;
  end

  assign EXwreg  = ex_q.wreg;
  assign EXm2reg = ex_q.m2reg;
  assign EXwmem  = ex_q.wmem;
  assign EXwn    = ex_q.wn;
  assign EXqb    = ex_q.qb;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;

  // Forwarded operands come from the live MEM/WB inputs, not registered copies.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    op_a = ex_q.qa;
    op_b = ex_q.qb;
    case (ex_q.sel_a)
      SEL_MEM: op_a = MEMalu;
      SEL_WB:  op_a = WBdata;
      SEL_IMM: op_a = ex_q.imm;
      default: op_a = ex_q.qa;
    endcase
    case (ex_q.sel_b)
      SEL_MEM: op_b = MEMalu;
      SEL_WB:  op_b = WBdata;
      SEL_IMM: op_b = ex_q.imm;
      default: op_b = ex_q.qb;
    endcase
  end

  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = op_a[4:0];

  always_comb begin
    EXalu = '0;
    EXovf = 1'b0;
    case (ex_q.aluc)
      ALU_ADD: begin
        EXalu = sum;
        EXovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      ALU_SUB: begin
        EXalu = diff;
        EXovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      ALU_AND:  EXalu = op_a & op_b;
      ALU_OR:   EXalu = op_a | op_b;
      ALU_XOR:  EXalu = op_a ^ op_b;
      ALU_NOR:  EXalu = ~(op_a | op_b);
      ALU_SLT:  EXalu = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: EXalu = {31'd0, op_a < op_b};
      ALU_SLL:  EXalu = op_b << shamt;
      ALU_SRL:  EXalu = op_b >> shamt;
      ALU_SRA:  EXalu = $unsigned($signed(op_b) >>> shamt);
      ALU_LUI:  EXalu = {op_b[15:0], 16'd0};
      ALU_PASB: EXalu = op_b;
      default:  EXalu = '0;
    endcase
  end

  assign EXzero = (EXalu == 32'd0);

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Self-checking bench for pipe_ex_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against an arithmetic model.
module tb_pipe_ex_stage;

  logic        clk = 1'b0;
  logic        clr, IFwip;
  logic        IDwreg, IDm2reg, IDwmem;
  logic [3:0]  IDaluc;
  logic [1:0]  IDselectAlua, IDselectAlub;
  logic [4:0]  IDwn;
  logic [31:0] IDqa, IDqb, IDsaOrImme, MEMalu, WBdata;
  logic        EXwreg, EXm2reg, EXwmem, EXzero, EXovf;
  logic [4:0]  EXwn;
  logic [31:0] EXalu, EXqb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ex_stage dut (
    .clk(clk), .clr(clr), .IFwip(IFwip),
    .IDwreg(IDwreg), .IDm2reg(IDm2reg), .IDwmem(IDwmem), .IDaluc(IDaluc),
    .IDselectAlua(IDselectAlua), .IDselectAlub(IDselectAlub), .IDwn(IDwn),
    .IDqa(IDqa), .IDqb(IDqb), .IDsaOrImme(IDsaOrImme),
    .MEMalu(MEMalu), .WBdata(WBdata),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem), .EXwn(EXwn),
    .EXalu(EXalu), .EXqb(EXqb), .EXzero(EXzero), .EXovf(EXovf)
  );

  typedef struct {
    logic        wreg, m2reg, wmem;
    logic [3:0]  aluc;
    logic [1:0]  sa, sb;
    logic [4:0]  wn;
    logic [31:0] qa, qb, imm;
  } id_t;

  typedef struct {
    string       name;
    logic        c, wip, wreg, wmem;
    logic [4:0]  wn;
    logic [3:0]  aluc;
    logic [1:0]  sa, sb;
    logic [31:0] qa, qb, imm, mem, wb;
    logic        e_wreg, e_wmem;
    logic [4:0]  e_wn;
    logic [31:0] e_alu;
    logic        e_zero, e_ovf;
  } vec_t;

  id_t  cur;
  id_t  held;
  logic cur_clr, cur_wip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input id_t d, input logic c, input logic w);
    cur = d; cur_clr = c; cur_wip = w;
    IDwreg = d.wreg; IDm2reg = d.m2reg; IDwmem = d.wmem; IDaluc = d.aluc;
    IDselectAlua = d.sa; IDselectAlub = d.sb; IDwn = d.wn;
    IDqa = d.qa; IDqb = d.qb; IDsaOrImme = d.imm;
    clr = c; IFwip = w;
  endtask

  // One rising edge; the model captures a bubble on reset or stall.
  task automatic tick();
    id_t nxt;
    nxt = cur;
    if (cur_clr || !cur_wip) nxt = '{default: 0};
    @(posedge clk);
    #1;
    held = nxt;
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint lim = 64'sd2147483648;
    longint p;
    int sh = int'(a[4:0]);
    p = 0; ovf = 1'b0;
    case (op)
      4'd0:  begin p = sa + sb; ovf = (p >= lim) || (p < -lim); end
      4'd1:  begin p = sa - sb; ovf = (p >= lim) || (p < -lim); end
      4'd2:  p = ua & ub;
      4'd3:  p = ua | ub;
      4'd4:  p = ua ^ ub;
      4'd5:  p = ~(ua | ub);
      4'd6:  p = (sa < sb) ? 1 : 0;
      4'd7:  p = (ua < ub) ? 1 : 0;
      4'd8:  p = ub * (longint'(1) << sh);
      4'd9:  p = ub / (longint'(1) << sh);
      4'd10: p = sb >>> sh;
      4'd11: p = ub * 65536;
      4'd12: p = ub;
      default: p = 0;
    endcase
    r = p[31:0];
  endfunction

  function automatic logic [31:0] pick_opnd(input logic [31:0] a, input id_t h, input logic [1:0] s);
    case (s)
      2'b01:   return MEMalu;
      2'b10:   return WBdata;
      2'b11:   return h.imm;
      default: return a;
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] a, b, r;
    logic ovf;
    a = pick_opnd(held.qa, held, held.sa);
    b = pick_opnd(held.qb, held, held.sb);
    ref_alu(held.aluc, a, b, r, ovf);
    check({tag, ".alu"},  EXalu, r);
    check({tag, ".zero"}, 32'(EXzero), 32'(r == 0));
    check({tag, ".ovf"},  32'(EXovf), 32'(ovf));
    check({tag, ".ctl"},  {29'd0, EXwreg, EXm2reg, EXwmem}, {29'd0, held.wreg, held.m2reg, held.wmem});
    check({tag, ".wn"},   32'(EXwn), 32'(held.wn));
    check({tag, ".qb"},   EXqb, held.qb);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  function automatic vec_t mk(input string n, input logic c, input logic w, input logic wr,
                              input logic wm, input logic [4:0] wn, input logic [3:0] op,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm,
                              input logic [31:0] mem, input logic [31:0] wb,
                              input logic ewr, input logic ewm, input logic [4:0] ewn,
                              input logic [31:0] ealu, input logic ez, input logic eo);
    vec_t v;
    v.name = n; v.c = c; v.wip = w; v.wreg = wr; v.wmem = wm; v.wn = wn; v.aluc = op;
    v.sa = sa; v.sb = sb; v.qa = qa; v.qb = qb; v.imm = imm; v.mem = mem; v.wb = wb;
    v.e_wreg = ewr; v.e_wmem = ewm; v.e_wn = ewn; v.e_alu = ealu; v.e_zero = ez; v.e_ovf = eo;
    return v;
  endfunction

  initial begin
    vec_t vecs[13];
    id_t  d;

    vecs[0]  = mk("reset",   1, 1, 1, 1, 3, 4'h0, 0, 0, 5, 6, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    vecs[1]  = mk("add_ovf", 0, 1, 1, 0, 2, 4'h0, 0, 0, 32'h7FFFFFFF, 1, 0, 0, 0, 1, 0, 2, 32'h80000000, 0, 1);
    vecs[2]  = mk("fwd_sub", 0, 1, 1, 0, 4, 4'h1, 1, 2, 0, 0, 0, 5, 3, 1, 0, 4, 32'd2, 0, 0);
    vecs[3]  = mk("sra",     0, 1, 1, 0, 5, 4'hA, 3, 0, 0, 32'h80000000, 32'h24, 0, 0, 1, 0, 5, 32'hF8000000, 0, 0);
    vecs[4]  = mk("srl",     0, 1, 1, 0, 5, 4'h9, 3, 0, 0, 32'h80000000, 32'h24, 0, 0, 1, 0, 5, 32'h08000000, 0, 0);
    vecs[5]  = mk("slt",     0, 1, 1, 0, 6, 4'h6, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0, 6, 32'd1, 0, 0);
    vecs[6]  = mk("sltu",    0, 1, 1, 0, 6, 4'h7, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0, 6, 32'd0, 1, 0);
    vecs[7]  = mk("stall",   0, 0, 1, 1, 7, 4'h0, 0, 0, 9, 9, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
    vecs[8]  = mk("sll0",    0, 1, 1, 0, 8, 4'h8, 0, 0, 32'h20, 32'h12345678, 0, 0, 0, 1, 0, 8, 32'h12345678, 0, 0);
    vecs[9]  = mk("lui",     0, 1, 1, 0, 9, 4'hB, 0, 0, 0, 32'h0000ABCD, 0, 0, 0, 1, 0, 9, 32'hABCD0000, 0, 0);
    vecs[10] = mk("nor",     0, 1, 0, 1, 1, 4'h5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 0, 0);
    vecs[11] = mk("op_e",    0, 1, 1, 0, 2, 4'hE, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2, 32'd0, 1, 0);
    vecs[12] = mk("sub_ovf", 0, 1, 1, 0, 3, 4'h1, 0, 0, 32'h80000000, 1, 0, 0, 0, 1, 0, 3, 32'h7FFFFFFF, 0, 1);

    MEMalu = '0; WBdata = '0;
    drive('{default: 0}, 1'b1, 1'b1);
    tick();
    check("post_reset.alu", EXalu, 32'd0);
    check("post_reset.flags", {29'd0, EXzero, EXovf, EXwreg}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("post_reset.qb", EXqb, 32'd0);

    foreach (vecs[i]) begin
      d = '{default: 0};
      d.wreg = vecs[i].wreg; d.wmem = vecs[i].wmem; d.wn = vecs[i].wn; d.aluc = vecs[i].aluc;
      d.sa = vecs[i].sa; d.sb = vecs[i].sb; d.qa = vecs[i].qa; d.qb = vecs[i].qb; d.imm = vecs[i].imm;
      drive(d, vecs[i].c, vecs[i].wip);
      tick();
      MEMalu = vecs[i].mem; WBdata = vecs[i].wb;
      #1;
      check({vecs[i].name, ".alu"},  EXalu, vecs[i].e_alu);
      check({vecs[i].name, ".wreg"}, 32'(EXwreg), 32'(vecs[i].e_wreg));
      check({vecs[i].name, ".wmem"}, 32'(EXwmem), 32'(vecs[i].e_wmem));
      check({vecs[i].name, ".wn"},   32'(EXwn), 32'(vecs[i].e_wn));
      check({vecs[i].name, ".zero"}, 32'(EXzero), 32'(vecs[i].e_zero));
      check({vecs[i].name, ".ovf"},  32'(EXovf), 32'(vecs[i].e_ovf));
    end

    // Forwarded operand follows MEMalu within the same cycle.
    d = '{default: 0}; d.aluc = 4'h1; d.sa = 2'b01; d.sb = 2'b10;
    drive(d, 1'b0, 1'b1);
    tick();
    MEMalu = 32'd5; WBdata = 32'd3; #1;
    check("fwd_live.first", EXalu, 32'd2);
    MEMalu = 32'd9; #1;
    check("fwd_live.second", EXalu, 32'd6);

    // Stall inserts a bubble, then the held ID values enter on release.
    d = '{default: 0}; d.wreg = 1; d.wmem = 1; d.wn = 5'd7; d.qa = 32'd4; d.qb = 32'd10;
    drive(d, 1'b0, 1'b0);
    tick();
    check("stall.ctl", {29'd0, EXwreg, EXwmem, EXm2reg}, 32'd0);
    check("stall.wn", 32'(EXwn), 32'd0);
    drive(d, 1'b0, 1'b1);
    tick();
    check("release.ctl", {30'd0, EXwreg, EXwmem}, 32'd3);
    check("release.wn", 32'(EXwn), 32'd7);
    check("release.alu", EXalu, 32'd14);

    // Reset mid-stream discards the in-flight write, even with stall asserted.
    d.m2reg = 1;
    drive(d, 1'b1, 1'b0);
    tick();
    check("midreset.ctl", {29'd0, EXwreg, EXwmem, EXm2reg}, 32'd0);
    check("midreset.alu", EXalu, 32'd0);

    for (int n = 0; n < 400; n++) begin
      d.wreg = 1'($urandom); d.m2reg = 1'($urandom); d.wmem = 1'($urandom);
      d.aluc = 4'($urandom); d.sa = 2'($urandom); d.sb = 2'($urandom);
      d.wn = 5'($urandom); d.qa = rnd_val(); d.qb = rnd_val(); d.imm = rnd_val();
      drive(d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      tick();
      MEMalu = rnd_val(); WBdata = rnd_val();
      #1;
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
